// File: rtl/bram_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bram_arb_pkg : shared types and round-robin pick helper for bram_port_arb
// Rev 1.0
// ---------------------------------------------------------------------------
package bram_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int ID_W    = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rd_tag_t;

  // Unused upper request bits are zero, so a mod-8 scan gives the same order as mod N_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                             input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] idx;
    rr_pick = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      idx = ptr + ID_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_port_arb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bram_port_arb_if : requester bundle and BRAM master port of bram_port_arb
// Rev 1.0
// ---------------------------------------------------------------------------
interface bram_port_arb_if #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic [N_REQ-1:0]                   Req_S;
  logic [N_REQ-1:0]                   Lock_S;
  logic [N_REQ-1:0][ADDR_WIDTH-1:0]   ReqAddr_D;
  logic [N_REQ-1:0][DATA_WIDTH-1:0]   ReqWrD_D;
  logic [N_REQ-1:0][DATA_WIDTH/8-1:0] ReqWrEn_S;
  logic [N_REQ-1:0]                   Gnt_S;
  logic [N_REQ-1:0]                   RspValid_S;
  logic [DATA_WIDTH-1:0]              RspRdD_D;

  logic                               Bram_Clk_C;
  logic                               Bram_Rst_R;
  logic                               Bram_En_S;
  logic [ADDR_WIDTH-1:0]              Bram_Addr_S;
  logic [DATA_WIDTH-1:0]              Bram_Wr_D;
  logic [DATA_WIDTH/8-1:0]            Bram_WrEn_S;
  logic [DATA_WIDTH-1:0]              Bram_Rd_D;

  // Arbiter view: takes requests and BRAM read data, drives grants and the BRAM port.
  modport slave (
    input  Req_S, Lock_S, ReqAddr_D, ReqWrD_D, ReqWrEn_S, Bram_Rd_D,
    output Gnt_S, RspValid_S, RspRdD_D,
    output Bram_Clk_C, Bram_Rst_R, Bram_En_S, Bram_Addr_S, Bram_Wr_D, Bram_WrEn_S
  );

  modport master (
    output Req_S, Lock_S, ReqAddr_D, ReqWrD_D, ReqWrEn_S, Bram_Rd_D,
    input  Gnt_S, RspValid_S, RspRdD_D,
    input  Bram_Clk_C, Bram_Rst_R, Bram_En_S, Bram_Addr_S, Bram_Wr_D, Bram_WrEn_S
  );

endinterface
`default_nettype wire

// File: rtl/bram_arb_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bram_arb_rr : round-robin pointer, lock owner and one-hot grant generation
// Rev 1.0
// ---------------------------------------------------------------------------
module bram_arb_rr
  import bram_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  wire logic             Clk_C,
  input  wire logic             Rst_RBI,
  input  wire logic [N_REQ-1:0] i_req,
  input  wire logic [N_REQ-1:0] i_lock,
  output logic      [N_REQ-1:0] o_gnt,
  output logic                  o_gnt_vld,
  output logic      [ID_W-1:0]  o_gnt_idx
);

  logic [ID_W-1:0]  r_ptr;
  logic             r_lock_vld;
  logic [ID_W-1:0]  r_lock_id;

  logic [N_REQ-1:0] w_owner_oh;
  logic             w_owner_req;
  logic             w_owner_lock;
  logic [ID_W-1:0]  w_pick;

  always_comb begin
    w_owner_oh = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_owner_oh[k] = (r_lock_id == ID_W'(k));
    end
  end

  assign w_owner_req  = |(i_req  & w_owner_oh);
  assign w_owner_lock = |(i_lock & w_owner_oh);
  assign w_pick       = rr_pick(MAX_REQ'(i_req), r_ptr);

  always_comb begin
    o_gnt_vld = r_lock_vld ? w_owner_req : |i_req;
    o_gnt_idx = r_lock_vld ? r_lock_id   : w_pick;
    o_gnt     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (o_gnt_vld && (o_gnt_idx == ID_W'(k))) o_gnt[k] = 1'b1;
    end
  end

  always_ff @(posedge Clk_C) begin
    if (!Rst_RBI) begin
      r_ptr      <= '0;
      r_lock_vld <= 1'b0;
      r_lock_id  <= '0;
    end else if (r_lock_vld) begin
      // The owner keeps the port until it drops Lock_S, even while it is idle.
      if (!w_owner_lock) r_lock_vld <= 1'b0;
    end else if (o_gnt_vld) begin
      r_ptr <= (o_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : o_gnt_idx + ID_W'(1);
      if (|(i_lock & o_gnt)) begin
        r_lock_vld <= 1'b1;
        r_lock_id  <= o_gnt_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_port_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bram_port_arb : round-robin sharing of one BRAM port with tagged read return
// Rev 1.0
// ---------------------------------------------------------------------------
module bram_port_arb
  import bram_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  wire logic       Clk_C,
  input  wire logic       Rst_RBI,
  bram_port_arb_if.slave  bus
);

  logic [N_REQ-1:0]        w_gnt;
  logic                    w_gnt_vld;
  logic [ID_W-1:0]         w_gnt_idx;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wrd;
  logic [DATA_WIDTH/8-1:0] w_wren;
  logic                    w_is_read;
  rd_tag_t                 w_tail;
  rd_tag_t                 r_tag [RD_LATENCY];

  bram_arb_rr #(
    .N_REQ (N_REQ)
  ) u_rr (
    .Clk_C     (Clk_C),
    .Rst_RBI   (Rst_RBI),
    .i_req     (bus.Req_S),
    .i_lock    (bus.Lock_S),
    .o_gnt     (w_gnt),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_addr = '0;
    w_wrd  = '0;
    w_wren = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt[k]) begin
        w_addr = bus.ReqAddr_D[k];
        w_wrd  = bus.ReqWrD_D[k];
        w_wren = bus.ReqWrEn_S[k];
      end
    end
  end

  assign w_is_read = w_gnt_vld && (w_wren == '0);

  // Tag pipeline mirrors the BRAM read latency so the tail lines up with Bram_Rd_D.
  always_ff @(posedge Clk_C) begin
    if (!Rst_RBI) begin
      for (int k = 0; k < RD_LATENCY; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0] <= rd_tag_t'{valid: w_is_read, id: w_gnt_idx};
      for (int k = 1; k < RD_LATENCY; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  assign w_tail = r_tag[RD_LATENCY-1];

  always_comb begin
    bus.RspValid_S = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_tail.valid && (w_tail.id == ID_W'(k))) bus.RspValid_S[k] = 1'b1;
    end
  end

  assign bus.Gnt_S       = w_gnt;
  assign bus.RspRdD_D    = bus.Bram_Rd_D;
  assign bus.Bram_Clk_C  = Clk_C;
  assign bus.Bram_Rst_R  = ~Rst_RBI;
  assign bus.Bram_En_S   = w_gnt_vld;
  assign bus.Bram_Addr_S = w_addr;
  assign bus.Bram_Wr_D   = w_wrd;
  assign bus.Bram_WrEn_S = w_wren;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arb.sv
`default_nettype none
// tb_bram_port_arb : drives identical stimulus into three arbiters (RD_LATENCY 1..3)
// and checks grants, BRAM-side muxing and delayed read responses.
module tb_bram_port_arb;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       req, lock;
  logic [1:0][31:0] addr, wrd;
  logic [1:0][3:0]  wren;

  logic [1:0]  gnt   [3];
  logic [1:0]  rsp   [3];
  logic [31:0] rdd   [3];
  logic        en    [3];
  logic [3:0]  bwen  [3];
  logic [31:0] baddr [3];
  logic [31:0] bwd   [3];
  logic        brst  [3];
  logic        bclk  [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_rst = -1;
  logic [1:0]  hist_gnt  [64];
  logic        hist_rd   [64];
  logic [31:0] hist_addr [64];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_lat
    localparam int L = gi + 1;
    bram_port_arb_if #(.N_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_if ();
    logic [31:0] rd_q [L];

    assign u_if.Req_S     = req;
    assign u_if.Lock_S    = lock;
    assign u_if.ReqAddr_D = addr;
    assign u_if.ReqWrD_D  = wrd;
    assign u_if.ReqWrEn_S = wren;

    bram_port_arb #(
      .N_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(L)
    ) u_dut (
      .Clk_C   (clk),
      .Rst_RBI (rst_n),
      .bus     (u_if.slave)
    );

    always @(posedge clk) begin
      rd_q[0] <= u_if.Bram_En_S ? mem_f(u_if.Bram_Addr_S) : 32'h0;
      for (int k = 1; k < L; k++) rd_q[k] <= rd_q[k-1];
    end
    assign u_if.Bram_Rd_D = rd_q[L-1];

    assign gnt[gi]   = u_if.Gnt_S;
    assign rsp[gi]   = u_if.RspValid_S;
    assign rdd[gi]   = u_if.RspRdD_D;
    assign en[gi]    = u_if.Bram_En_S;
    assign bwen[gi]  = u_if.Bram_WrEn_S;
    assign baddr[gi] = u_if.Bram_Addr_S;
    assign bwd[gi]   = u_if.Bram_Wr_D;
    assign brst[gi]  = u_if.Bram_Rst_R;
    assign bclk[gi]  = u_if.Bram_Clk_C;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] lk,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [3:0] w0, input logic [3:0] w1);
    req     = r;
    lock    = lk;
    addr[0] = a0;
    addr[1] = a1;
    wrd[0]  = a0 ^ 32'h5555_5555;
    wrd[1]  = a1 ^ 32'hAAAA_0000;
    wren[0] = w0;
    wren[1] = w1;
  endtask

  // One cycle: inputs already driven; eg is the hand-computed grant for this cycle.
  task automatic do_cyc(input logic [1:0] eg);
    int         idx, t;
    logic       e_en;
    logic [3:0] e_wren;
    logic [1:0] e_rsp;
    @(negedge clk);
    #1;
    idx    = eg[1] ? 1 : 0;
    e_en   = |eg;
    e_wren = e_en ? wren[idx] : 4'h0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("L%0d_gnt", i + 1), 64'(gnt[i]), 64'(eg));
      check($sformatf("L%0d_en", i + 1), 64'(en[i]), 64'(e_en));
      check($sformatf("L%0d_wren", i + 1), 64'(bwen[i]), 64'(e_wren));
      check($sformatf("L%0d_brst", i + 1), 64'(brst[i]), 64'(!rst_n));
      check($sformatf("L%0d_bclk", i + 1), 64'(bclk[i]), 64'(1'b0));
      if (e_en) check($sformatf("L%0d_addr", i + 1), 64'(baddr[i]), 64'(addr[idx]));
      if (e_wren != 4'h0) check($sformatf("L%0d_wdata", i + 1), 64'(bwd[i]), 64'(wrd[idx]));
      t     = cyc - (i + 1);
      e_rsp = 2'b00;
      if (t >= 0 && t > last_rst && hist_rd[t]) e_rsp = hist_gnt[t];
      check($sformatf("L%0d_rsp", i + 1), 64'(rsp[i]), 64'(e_rsp));
      if (e_rsp != 2'b00) check($sformatf("L%0d_rdata", i + 1), 64'(rdd[i]), 64'(mem_f(hist_addr[t])));
    end
    hist_gnt[cyc]  = eg;
    hist_rd[cyc]   = e_en && (e_wren == 4'h0);
    hist_addr[cyc] = addr[idx];
    if (!rst_n) last_rst = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 32'h0, 32'h0, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle port, then a single read of 0xDEADBEEF at 0x10
    drive(2'b00, 2'b00, 32'h0,  32'h0, 4'h0, 4'h0); do_cyc(2'b00);
    drive(2'b01, 2'b00, 32'h10, 32'h0, 4'h0, 4'h0); do_cyc(2'b01);
    // Locked read by requester 0, then reset one cycle later
    drive(2'b01, 2'b01, 32'h14, 32'h0, 4'h0, 4'h0); do_cyc(2'b01);
    rst_n = 1'b0;
    drive(2'b00, 2'b01, 32'h0,  32'h0, 4'h0, 4'h0); do_cyc(2'b00);
    rst_n = 1'b1;
    // Lock must be gone: requester 1 wins although Lock_S[0] is still high
    drive(2'b10, 2'b01, 32'h0,  32'h24, 4'h0, 4'h0); do_cyc(2'b10);
    drive(2'b01, 2'b00, 32'h18, 32'h0,  4'h0, 4'h0); do_cyc(2'b01);
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 32'h0,  32'h0,  4'h0, 4'h0); do_cyc(2'b00);
    rst_n = 1'b1;
    // Contention from reset: pointer restarts at 0, grants alternate
    for (int k = 0; k < 5; k++) begin
      drive(2'b11, 2'b00, 32'h100 + 32'(4 * k), 32'h200 + 32'(4 * k), 4'h0, 4'h0);
      do_cyc((k % 2 == 0) ? 2'b01 : 2'b10);
    end
    // Locked read-modify-write by requester 1 while requester 0 keeps asking
    drive(2'b11, 2'b10, 32'h30, 32'h20, 4'h0, 4'h0); do_cyc(2'b10);
    drive(2'b01, 2'b10, 32'h34, 32'h0,  4'h0, 4'h0); do_cyc(2'b00);
    drive(2'b11, 2'b00, 32'h38, 32'h20, 4'h0, 4'hF); do_cyc(2'b10);
    drive(2'b01, 2'b00, 32'h3C, 32'h0,  4'h0, 4'h0); do_cyc(2'b01);
    // Read then write back-to-back
    drive(2'b11, 2'b00, 32'h40, 32'h44, 4'h3, 4'h0); do_cyc(2'b10);
    drive(2'b11, 2'b00, 32'h40, 32'h48, 4'h3, 4'h0); do_cyc(2'b01);
    // Drain outstanding responses on an idle port
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 2'b00, 32'h0, 32'h0, 4'h0, 4'h0);
      do_cyc(2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
